// File: rtl/uvmt_cv32e40x_sl_trigger_csr_shadow.sv
// rtl/uvmt_cv32e40x_sl_trigger_csr_shadow.sv - shadow tselect/tdata1/tdata2 state built from retired RVFI CSR writes
// Applies WARL legalisation and hit-bit tracking; outputs are registered per-trigger arrays.

module uvmt_cv32e40x_sl_trigger_csr_shadow #(
  parameter int          NUM_TRIGGERS = 4,
  parameter logic [31:0] TDATA1_RESET = 32'hF800_0000
) (
  input  logic                                                  clk_i,
  input  logic                                                  rst_ni,
  input  logic                                                  rvfi_valid,
  input  logic                                                  rvfi_trap_exception,
  input  logic                                                  rvfi_dbg_mode,
  input  logic                                                  csr_we,
  input  logic [11:0]                                           csr_addr,
  input  logic [31:0]                                           csr_wdata,
  input  logic [((NUM_TRIGGERS > 0) ? NUM_TRIGGERS : 1)-1:0]    trigger_hit,
  output logic [31:0]                                           tselect_o,
  output logic [NUM_TRIGGERS:0][31:0]                           tdata1_array,
  output logic [NUM_TRIGGERS:0][31:0]                           tdata2_array
);

  localparam int NT = (NUM_TRIGGERS > 0) ? NUM_TRIGGERS : 1;

  localparam logic [11:0] ADDR_TSELECT = 12'h7A0;
  localparam logic [11:0] ADDR_TDATA1  = 12'h7A1;
  localparam logic [11:0] ADDR_TDATA2  = 12'h7A2;

  localparam logic [3:0] TYPE_MCONTROL  = 4'd2;
  localparam logic [3:0] TYPE_ETRIGGER  = 4'd5;
  localparam logic [3:0] TYPE_MCONTROL6 = 4'd6;
  localparam logic [3:0] TYPE_DISABLED  = 4'hF;

  // WARL view of a tdata1 write; dmode can only be set from debug mode.
  function automatic logic [31:0] legalize_tdata1(input logic [31:0] wdata, input logic dbg_mode);
    logic [3:0]  ttype;
    logic        dmode;
    logic [3:0]  match;
    logic [3:0]  action;
    logic [31:0] r;
    ttype  = wdata[31:28];
    dmode  = wdata[27] & dbg_mode;
    match  = wdata[10:7];
    action = (wdata[15:12] == 4'd1) ? 4'd1 : 4'd0;
    r      = '0;
    if (!(match == 4'd0 || match == 4'd2 || match == 4'd3)) begin
      match = 4'd0;
    end
    case (ttype)
      TYPE_MCONTROL, TYPE_MCONTROL6: begin
        r = {ttype, dmode, 4'b0, wdata[22], 6'b0, action, 1'b0, match,
             wdata[6], 2'b0, wdata[3], wdata[2:0]};
      end
      TYPE_ETRIGGER: begin
        r = {ttype, dmode, 17'b0, wdata[9], 2'b0, wdata[6], 6'd1};
      end
      default: begin
        r = {TYPE_DISABLED, dmode, 27'b0};
      end
    endcase
    return r;
  endfunction

  logic [31:0] tselect_q, tselect_d;
  logic [31:0] tdata1_q [NT];
  logic [31:0] tdata1_d [NT];
  logic [31:0] tdata2_q [NT];
  logic [31:0] tdata2_d [NT];

  logic        commit;
  logic        wr_guard;
  logic [31:0] sel_tdata1;

  always_comb begin
    sel_tdata1 = '0;
    for (int t = 0; t < NT; t++) begin
      if (tselect_q == 32'(t)) begin
        sel_tdata1 = tdata1_q[t];
      end
    end
  end

  assign commit   = rvfi_valid && !rvfi_trap_exception && csr_we;
  assign wr_guard = sel_tdata1[27] && !rvfi_dbg_mode;

  always_comb begin
    tselect_d = tselect_q;
    if (commit && csr_addr == ADDR_TSELECT && csr_wdata < 32'(NUM_TRIGGERS)) begin
      tselect_d = csr_wdata;
    end
  end

  // The hit is applied first so that a same-cycle CSR write overrides it.
  always_comb begin
    for (int t = 0; t < NT; t++) begin
      tdata1_d[t] = tdata1_q[t];
      tdata2_d[t] = tdata2_q[t];
      if (rvfi_valid && trigger_hit[t] &&
          (tdata1_q[t][31:28] == TYPE_MCONTROL || tdata1_q[t][31:28] == TYPE_MCONTROL6)) begin
        tdata1_d[t][22] = 1'b1;
      end
      if (commit && !wr_guard && tselect_q == 32'(t)) begin
        if (csr_addr == ADDR_TDATA1) begin
          tdata1_d[t] = legalize_tdata1(csr_wdata, rvfi_dbg_mode);
        end
        if (csr_addr == ADDR_TDATA2) begin
          tdata2_d[t] = csr_wdata;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tselect_q <= '0;
      for (int t = 0; t < NT; t++) begin
        tdata1_q[t] <= TDATA1_RESET;
        tdata2_q[t] <= '0;
      end
    end else begin
      tselect_q <= tselect_d;
      for (int t = 0; t < NT; t++) begin
        tdata1_q[t] <= tdata1_d[t];
        tdata2_q[t] <= tdata2_d[t];
      end
    end
  end

  assign tselect_o = tselect_q;

  for (genvar t = 0; t <= NUM_TRIGGERS; t++) begin : g_out
    if (t < NUM_TRIGGERS) begin : g_impl
      assign tdata1_array[t] = tdata1_q[t];
      assign tdata2_array[t] = tdata2_q[t];
    end else begin : g_pad
      assign tdata1_array[t] = '0;
      assign tdata2_array[t] = '0;
    end
  end

endmodule

// File: tb/tb_uvmt_cv32e40x_sl_trigger_csr_shadow.sv
// tb/tb_uvmt_cv32e40x_sl_trigger_csr_shadow.sv - scoreboard bench for the trigger CSR shadow
// Expected state is pushed when a retirement is driven and popped one cycle later.

module tb_uvmt_cv32e40x_sl_trigger_csr_shadow;

  localparam int N = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              rvfi_valid = 1'b0;
  logic              rvfi_trap_exception = 1'b0;
  logic              rvfi_dbg_mode = 1'b0;
  logic              csr_we = 1'b0;
  logic [11:0]       csr_addr = '0;
  logic [31:0]       csr_wdata = '0;
  logic [N-1:0]      trigger_hit = '0;
  logic [31:0]       tselect_o;
  logic [N:0][31:0]  tdata1_array;
  logic [N:0][31:0]  tdata2_array;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0]        tsel;
    logic [N-1:0][31:0] t1;
    logic [N-1:0][31:0] t2;
  } exp_t;

  exp_t sb[$];

  logic [31:0]        m_tsel;
  logic [N-1:0][31:0] m_t1;
  logic [N-1:0][31:0] m_t2;

  uvmt_cv32e40x_sl_trigger_csr_shadow #(
    .NUM_TRIGGERS (N),
    .TDATA1_RESET (32'hF800_0000)
  ) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .rvfi_valid          (rvfi_valid),
    .rvfi_trap_exception (rvfi_trap_exception),
    .rvfi_dbg_mode       (rvfi_dbg_mode),
    .csr_we              (csr_we),
    .csr_addr            (csr_addr),
    .csr_wdata           (csr_wdata),
    .trigger_hit         (trigger_hit),
    .tselect_o           (tselect_o),
    .tdata1_array        (tdata1_array),
    .tdata2_array        (tdata2_array)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model_legal(input logic [31:0] w, input logic dbg);
    logic [3:0]  ty;
    logic [31:0] r;
    ty = w[31:28];
    r  = '0;
    case (ty)
      4'd2, 4'd6: begin
        r = w & 32'h0040_004F;
        if (w[10:7] == 4'd0 || w[10:7] == 4'd2 || w[10:7] == 4'd3) r = r | (w & 32'h0000_0780);
        if (w[15:12] == 4'd1) r = r | 32'h0000_1000;
      end
      4'd5: r = (w & 32'h0000_0240) | 32'h1;
      default: begin
        ty = 4'hF;
        r  = '0;
      end
    endcase
    return {ty, w[27] & dbg, r[26:0]};
  endfunction

  task automatic model_reset();
    m_tsel = '0;
    for (int t = 0; t < N; t++) begin
      m_t1[t] = 32'hF800_0000;
      m_t2[t] = '0;
    end
  endtask

  task automatic model_step(input logic v, input logic trap, input logic dbg, input logic we,
                            input logic [11:0] a, input logic [31:0] d, input logic [N-1:0] h);
    logic               cm;
    logic               blocked;
    logic [31:0]        n_tsel;
    logic [N-1:0][31:0] n_t1;
    logic [N-1:0][31:0] n_t2;
    cm      = v && !trap && we;
    blocked = m_t1[m_tsel[1:0]][27] && !dbg;
    n_tsel  = m_tsel;
    n_t1    = m_t1;
    n_t2    = m_t2;
    for (int t = 0; t < N; t++) begin
      if (v && h[t] && (m_t1[t][31:28] == 4'd2 || m_t1[t][31:28] == 4'd6)) n_t1[t][22] = 1'b1;
    end
    if (cm && a == 12'h7A0 && d < N) n_tsel = d;
    if (cm && a == 12'h7A1 && !blocked) n_t1[m_tsel[1:0]] = model_legal(d, dbg);
    if (cm && a == 12'h7A2 && !blocked) n_t2[m_tsel[1:0]] = d;
    m_tsel = n_tsel;
    m_t1   = n_t1;
    m_t2   = n_t2;
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk("tselect", tselect_o, e.tsel);
    for (int t = 0; t < N; t++) begin
      chk($sformatf("tdata1[%0d]", t), tdata1_array[t], e.t1[t]);
      chk($sformatf("tdata2[%0d]", t), tdata2_array[t], e.t2[t]);
    end
    chk("tdata1_pad", tdata1_array[N], 32'd0);
    chk("tdata2_pad", tdata2_array[N], 32'd0);
  endtask

  task automatic step(input logic v, input logic trap, input logic dbg, input logic we,
                      input logic [11:0] a, input logic [31:0] d, input logic [N-1:0] h);
    exp_t e;
    rvfi_valid          = v;
    rvfi_trap_exception = trap;
    rvfi_dbg_mode       = dbg;
    csr_we              = we;
    csr_addr            = a;
    csr_wdata           = d;
    trigger_hit         = h;
    model_step(v, trap, dbg, we, a, d, h);
    e.tsel = m_tsel;
    e.t1   = m_t1;
    e.t2   = m_t2;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    compare_out();
  endtask

  task automatic wr(input logic dbg, input logic [11:0] a, input logic [31:0] d);
    step(1'b1, 1'b0, dbg, 1'b1, a, d, '0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_tsel"}, tselect_o, 32'd0);
    for (int t = 0; t < N; t++) begin
      chk({tag, "_t1"}, tdata1_array[t], 32'hF800_0000);
      chk({tag, "_t2"}, tdata2_array[t], 32'd0);
    end
  endtask

  initial begin
    logic [11:0] ra;
    logic [31:0] rd;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_values("in_reset");
    rst_ni = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'd0, '0);
    check_reset_values("after_reset");

    wr(1'b0, 12'h7A0, 32'd1);
    chk("tsel_1", tselect_o, 32'd1);
    wr(1'b0, 12'h7A1, 32'h6000_0043);
    chk("t1_dmode_blocked", tdata1_array[1], 32'hF800_0000);
    wr(1'b1, 12'h7A1, 32'h6000_0043);
    chk("t1_mc6", tdata1_array[1], 32'h6000_0043);
    wr(1'b0, 12'h7A2, 32'h0000_1000);
    chk("t2_write", tdata2_array[1], 32'h0000_1000);
    chk("t1_0_untouched", tdata1_array[0], 32'hF800_0000);
    wr(1'b0, 12'h7A0, 32'd4);
    chk("tsel_warl", tselect_o, 32'd1);
    wr(1'b0, 12'h7A1, 32'h2000_0004);
    chk("t1_old_sel", tdata1_array[1], 32'h2000_0004);

    wr(1'b0, 12'h7A0, 32'd2);
    wr(1'b0, 12'h7A1, 32'h6800_0004);
    chk("t1_mmode_ignored", tdata1_array[2], 32'hF800_0000);
    wr(1'b1, 12'h7A1, 32'h6800_0004);
    chk("t1_dbg_dmode", tdata1_array[2], 32'h6800_0004);

    wr(1'b0, 12'h7A0, 32'd1);
    wr(1'b0, 12'h7A1, 32'h3800_0000);
    chk("t1_type3", tdata1_array[1], 32'hF000_0000);
    wr(1'b0, 12'h7A1, 32'h2000_0084);
    chk("t1_match1", tdata1_array[1], 32'h2000_0004);
    wr(1'b0, 12'h7A1, 32'h2000_1117);
    chk("t1_s_action", tdata1_array[1], 32'h2000_1107);
    wr(1'b0, 12'h7A1, 32'h5800_027F);
    chk("t1_etrigger", tdata1_array[1], 32'h5000_0241);

    wr(1'b0, 12'h7A0, 32'd0);
    wr(1'b1, 12'h7A1, 32'h6000_0004);
    step(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'd0, 4'b0001);
    chk("hit_no_valid", tdata1_array[0], 32'h6000_0004);
    step(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 32'd0, 4'b0001);
    chk("hit_set", tdata1_array[0], 32'h6040_0004);
    step(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 32'd0, 4'b1000);
    chk("hit_disabled", tdata1_array[3], 32'hF800_0000);
    step(1'b1, 1'b0, 1'b0, 1'b1, 12'h7A1, 32'h6000_0004, 4'b0001);
    chk("hit_vs_write", tdata1_array[0], 32'h6000_0004);
    step(1'b1, 1'b1, 1'b0, 1'b1, 12'h7A0, 32'd3, '0);
    chk("trap_ignored", tselect_o, 32'd0);
    wr(1'b1, 12'h7A3, 32'hFFFF_FFFF);

    for (int i = 0; i < 120; i++) begin
      ra = 12'h7A0 + 12'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: rd = 32'($urandom_range(0, 5));
        1: rd = {4'($urandom_range(0, 15)), 28'($urandom)};
        2: rd = {4'd6, 28'($urandom)};
        default: rd = $urandom;
      endcase
      step($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, 1'($urandom),
           $urandom_range(0, 3) != 0, ra, rd, 4'($urandom));
    end

    rvfi_valid          = 1'b1;
    rvfi_trap_exception = 1'b0;
    rvfi_dbg_mode       = 1'b1;
    csr_we              = 1'b1;
    csr_addr            = 12'h7A1;
    csr_wdata           = 32'h6000_0047;
    trigger_hit         = '1;
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(posedge clk_i);
    #1;
    check_reset_values("reset_hold");
    rvfi_valid  = 1'b0;
    csr_we      = 1'b0;
    trigger_hit = '0;
    rst_ni      = 1'b1;
    model_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'd0, '0);
    wr(1'b1, 12'h7A1, 32'h6000_0047);
    chk("post_reset_write", tdata1_array[0], 32'h6000_0047);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
